adder_share_arbiter: RTL and testbench
======================================

// Module: adder_share_arbiter
// PURPOSE
//  Shares one 32-bit FullAdder32bit add/subtract datapath among NUM_REQ requesters (PC incr, branch target, ALU, ...).
//  Round-robin arbitration; one operation in flight; registered operands; valid/ready response channel.
//  Sits between the pipeline requesters and the single adder instance.
// PARAMETERS
//  WIDTH    32  operand/sum width (adder instance is WIDTH bits)
//  NUM_REQ  4   number of requesters (2..8)
//  ID_W     2   width of rsp_id; must satisfy 2**ID_W >= NUM_REQ
// PORTS
//  clk           in   1              rising-edge clock
//  reset         in   1              asynchronous, active-high reset
//  req_valid     in   NUM_REQ        per-requester request pending
//  req_ready     out  NUM_REQ        one-hot grant/accept; never more than one bit set
//  req_a         in   NUM_REQ*WIDTH  operand A, requester i at [i*WIDTH +: WIDTH]
//  req_b         in   NUM_REQ*WIDTH  operand B, same packing
//  req_sub       in   NUM_REQ        1 = a-b, 0 = a+b
//  rsp_valid     out  1              result available
//  rsp_ready     in   1              consumer accepts result
//  rsp_id        out  ID_W           index of requester owning the result
//  rsp_sum       out  WIDTH          sum/difference
//  rsp_carryout  out  1              raw adder carry-out (subtract: 1 = no borrow)
//  rsp_overflow  out  1              signed two's-complement overflow
// BEHAVIOUR
//  - Reset (async): state IDLE, rsp_valid=0, rsp_id=0, operand regs=0, sub reg=0 (so rsp_sum=0, carry=0, ovf=0),
//    RR pointer=0 (requester 0 highest priority). In-flight op is dropped; requester must reissue.
//  - States: IDLE (no result held) / BUSY (result held, rsp_valid=1).
//  - accept_en = (state==IDLE) | (state==BUSY & rsp_ready). req_ready is combinational: when accept_en,
//    the winning req_valid bit is set; otherwise all zeros. Transfer = req_valid[i] & req_ready[i].
//  - On transfer: capture a, b, sub, id into regs; state->BUSY; rsp_valid=1 next cycle (latency 1).
//  - BUSY & rsp_ready & no transfer -> IDLE, rsp_valid=0. BUSY & rsp_ready & transfer -> stays BUSY,
//    new result next cycle (back-to-back, full throughput 1 op/cycle). BUSY & !rsp_ready -> hold all rsp_* stable.
//  - Round-robin: search starts at ptr, wraps NUM_REQ-1 -> 0; after a transfer from i, ptr=(i+1) mod NUM_REQ.
//    No transfer -> ptr unchanged. Requesters must hold valid and operands until ready.
//  - Arithmetic: adder driven from captured regs; sub: a + ~b + 1. overflow = carry into MSB XOR carry out of MSB.
//    Results wrap modulo 2**WIDTH; no saturation.
//  - req_valid dropping before grant is legal; no state change.
// CONFIGURATION
//  ADDER_ARB_FIXED_PRIO_EN defined: fixed priority, lowest index wins; RR pointer removed (ptr held at 0).
//  Not defined (default): round-robin as above. Ports and latency are identical in both builds.
// TESTING
//  1 reset mid-BUSY (rsp_valid=1) -> rsp_valid=0, rsp_sum=0, req_ready=0 immediately, no clk edge needed.
//  2 req0 add a=FFFFFFFF b=FFFFFFFF -> next cycle rsp_valid=1 id=0 sum=FFFFFFFE carry=1 ovf=0.
//  3 req1 sub a=AAAAAAAA b=55555555 -> sum=55555555 carry=1 ovf=1; req2 add 55555555+55555555 -> AAAAAAAA carry=0 ovf=1.
//  4 all 4 valid continuously, rsp_ready=1 -> grants 0,1,2,3,0 on consecutive cycles, rsp_valid held 1
//    (FIXED_PRIO build: req0 every cycle).
//  5 rsp_ready=0 for 3 cycles with req3 valid -> req_ready=0, rsp_* stable; raise rsp_ready -> same cycle req3 accepted.
//  6 req2 sub a=2 b=1 -> sum=00000001 carry=1 ovf=0, id=2; req_valid pulsed 1 cycle while BUSY&!rsp_ready -> ignored.

Source files
------------

// File: rtl/adder_share_arbiter.sv
// Round-robin arbiter sharing one WIDTH-bit add/subtract datapath among NUM_REQ requesters.
// Define ADDER_ARB_FIXED_PRIO_EN for fixed priority (lowest index wins) instead of round-robin.
module adder_share_arbiter #(
    parameter int WIDTH   = 32,
    parameter int NUM_REQ = 4,
    parameter int ID_W    = 2
) (
    input  logic                     clk,
    input  logic                     reset,
    input  logic [NUM_REQ-1:0]       req_valid,
    output logic [NUM_REQ-1:0]       req_ready,
    input  logic [NUM_REQ*WIDTH-1:0] req_a,
    input  logic [NUM_REQ*WIDTH-1:0] req_b,
    input  logic [NUM_REQ-1:0]       req_sub,
    output logic                     rsp_valid,
    input  logic                     rsp_ready,
    output logic [ID_W-1:0]          rsp_id,
    output logic [WIDTH-1:0]         rsp_sum,
    output logic                     rsp_carryout,
    output logic                     rsp_overflow
);

    // Handshake: a request transfers when req_valid[i] & req_ready[i]; the
    // response transfers when rsp_valid & rsp_ready, and rsp_* hold otherwise.
    typedef enum logic {IDLE = 1'b0, BUSY = 1'b1} state_t;

    state_t           state_q, state_d;
    logic [WIDTH-1:0] a_q, a_d;
    logic [WIDTH-1:0] b_q, b_d;
    logic             sub_q, sub_d;
    logic [ID_W-1:0]  id_q, id_d;
    logic [ID_W-1:0]  ptr_q;
`ifndef ADDER_ARB_FIXED_PRIO_EN
    logic [ID_W-1:0]  ptr_d;
`else
    assign ptr_q = '0;
`endif

    logic            accept_en;
    logic            found;
    logic            transfer;
    logic [ID_W-1:0] grant_idx;
    int              cand;

    // Reset also blocks grants so nothing is accepted while it is held.
    assign accept_en = !reset && ((state_q == IDLE) || rsp_ready);
    assign transfer  = accept_en && found;

    always_comb begin
        found     = 1'b0;
        grant_idx = '0;
        cand      = 0;
        for (int k = 0; k < NUM_REQ; k++) begin
            cand = int'(ptr_q) + k;
            if (cand >= NUM_REQ) cand = cand - NUM_REQ;
            if (!found && req_valid[cand]) begin
                found     = 1'b1;
                grant_idx = cand[ID_W-1:0];
            end
        end
    end

    always_comb begin
        req_ready = '0;
        for (int i = 0; i < NUM_REQ; i++) begin
            if (transfer && (grant_idx == ID_W'(i))) req_ready[i] = 1'b1;
        end
    end

    always_comb begin
        state_d = state_q;
        a_d     = a_q;
        b_d     = b_q;
        sub_d   = sub_q;
        id_d    = id_q;
        if (transfer) begin
            state_d = BUSY;
            id_d    = grant_idx;
            for (int i = 0; i < NUM_REQ; i++) begin
                if (req_ready[i]) begin
                    a_d   = req_a[i*WIDTH +: WIDTH];
                    b_d   = req_b[i*WIDTH +: WIDTH];
                    sub_d = req_sub[i];
                end
            end
        end else if ((state_q == BUSY) && rsp_ready) begin
            state_d = IDLE;
        end
    end

`ifndef ADDER_ARB_FIXED_PRIO_EN
    always_comb begin
        ptr_d = ptr_q;
        if (transfer) begin
            if (int'(grant_idx) == NUM_REQ - 1) ptr_d = '0;
            else                                ptr_d = grant_idx + ID_W'(1);
        end
    end
`endif

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q <= IDLE;
            a_q     <= '0;
            b_q     <= '0;
            sub_q   <= 1'b0;
            id_q    <= '0;
`ifndef ADDER_ARB_FIXED_PRIO_EN
            ptr_q   <= '0;
`endif
        end else begin
            state_q <= state_d;
            a_q     <= a_d;
            b_q     <= b_d;
            sub_q   <= sub_d;
            id_q    <= id_d;
`ifndef ADDER_ARB_FIXED_PRIO_EN
            ptr_q   <= ptr_d;
`endif
        end
    end

    // Shared adder: subtract is a + ~b + 1.
    logic [WIDTH-1:0] b_eff;
    logic [WIDTH:0]   sum_full;

    assign b_eff    = sub_q ? ~b_q : b_q;
    assign sum_full = {1'b0, a_q} + {1'b0, b_eff} + {{WIDTH{1'b0}}, sub_q};

    assign rsp_valid    = (state_q == BUSY);
    assign rsp_id       = id_q;
    assign rsp_sum      = sum_full[WIDTH-1:0];
    assign rsp_carryout = sum_full[WIDTH];
    // Same as carry-in-to-MSB XOR carry-out: like-signed operands, differently signed sum.
    assign rsp_overflow = (a_q[WIDTH-1] == b_eff[WIDTH-1]) && (sum_full[WIDTH-1] != a_q[WIDTH-1]);

endmodule

// File: tb/tb_adder_share_arbiter.sv
// Directed self-checking bench for adder_share_arbiter (WIDTH=32, NUM_REQ=4).
module tb_adder_share_arbiter;

    logic         clk;
    logic         reset;
    logic [3:0]   req_valid;
    logic [3:0]   req_ready;
    logic [127:0] req_a;
    logic [127:0] req_b;
    logic [3:0]   req_sub;
    logic         rsp_valid;
    logic         rsp_ready;
    logic [1:0]   rsp_id;
    logic [31:0]  rsp_sum;
    logic         rsp_carryout;
    logic         rsp_overflow;

    int errors = 0;
    int checks = 0;
    int prev_g;
    int exp_g;

    adder_share_arbiter #(.WIDTH(32), .NUM_REQ(4), .ID_W(2)) dut (
        .clk(clk), .reset(reset),
        .req_valid(req_valid), .req_ready(req_ready),
        .req_a(req_a), .req_b(req_b), .req_sub(req_sub),
        .rsp_valid(rsp_valid), .rsp_ready(rsp_ready),
        .rsp_id(rsp_id), .rsp_sum(rsp_sum),
        .rsp_carryout(rsp_carryout), .rsp_overflow(rsp_overflow)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic set_op(input int i, input logic [31:0] a, input logic [31:0] b, input logic s);
        req_a[i*32 +: 32] = a;
        req_b[i*32 +: 32] = b;
        req_sub[i]        = s;
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic chk_rsp(input string tag, input logic [1:0] id, input logic [31:0] sum,
                           input logic c, input logic v);
        chk({tag, "_valid"}, 64'(rsp_valid), 64'(1'b1));
        chk({tag, "_id"},    64'(rsp_id), 64'(id));
        chk({tag, "_sum"},   64'(rsp_sum), 64'(sum));
        chk({tag, "_carry"}, 64'(rsp_carryout), 64'(c));
        chk({tag, "_ovf"},   64'(rsp_overflow), 64'(v));
    endtask

    initial begin
        reset     = 1'b1;
        req_valid = '0;
        req_a     = '0;
        req_b     = '0;
        req_sub   = '0;
        rsp_ready = 1'b0;
        #2;
        chk("rst_valid", 64'(rsp_valid), 64'(0));
        chk("rst_sum",   64'(rsp_sum), 64'(0));
        chk("rst_id",    64'(rsp_id), 64'(0));
        chk("rst_carry", 64'(rsp_carryout), 64'(0));
        chk("rst_ovf",   64'(rsp_overflow), 64'(0));
        req_valid = 4'b0001;
        #1;
        chk("rst_ready", 64'(req_ready), 64'(0));
        req_valid = '0;
        step();
        reset = 1'b0;

        // req0 add FFFFFFFF + FFFFFFFF
        set_op(0, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 1'b0);
        req_valid = 4'b0001;
        rsp_ready = 1'b1;
        #1;
        chk("t2_grant", 64'(req_ready), 64'(4'b0001));
        step();
        req_valid = '0;
        #1;
        chk_rsp("t2", 2'd0, 32'hFFFF_FFFE, 1'b1, 1'b0);
        chk("t2_noready", 64'(req_ready), 64'(0));
        step();
        chk("t2_idle", 64'(rsp_valid), 64'(0));

        // req1 sub then req2 add, back to back
        set_op(1, 32'hAAAA_AAAA, 32'h5555_5555, 1'b1);
        req_valid = 4'b0010;
        #1;
        chk("t3_grant1", 64'(req_ready), 64'(4'b0010));
        step();
        set_op(2, 32'h5555_5555, 32'h5555_5555, 1'b0);
        req_valid = 4'b0100;
        #1;
        chk_rsp("t3a", 2'd1, 32'h5555_5555, 1'b1, 1'b1);
        chk("t3_grant2", 64'(req_ready), 64'(4'b0100));
        step();
        req_valid = '0;
        #1;
        chk_rsp("t3b", 2'd2, 32'hAAAA_AAAA, 1'b0, 1'b1);
        step();
        chk("t3_idle", 64'(rsp_valid), 64'(0));

        // all four requesting continuously from a fresh pointer
        reset = 1'b1;
        #1;
        reset = 1'b0;
        for (int i = 0; i < 4; i++) set_op(i, 32'(i + 1), 32'd10, 1'b0);
        req_valid = 4'b1111;
        rsp_ready = 1'b1;
        prev_g    = 0;
        for (int c = 0; c < 5; c++) begin
            #1;
`ifdef ADDER_ARB_FIXED_PRIO_EN
            exp_g = 0;
`else
            exp_g = c % 4;
`endif
            chk($sformatf("t4_grant%0d", c), 64'(req_ready), 64'(4'b0001 << exp_g));
            if (c > 0) begin
                chk($sformatf("t4_valid%0d", c), 64'(rsp_valid), 64'(1'b1));
                chk($sformatf("t4_id%0d", c), 64'(rsp_id), 64'(prev_g));
                chk($sformatf("t4_sum%0d", c), 64'(rsp_sum), 64'(prev_g + 11));
            end
            prev_g = exp_g;
            step();
        end

        // consumer stalls with req3 waiting; last result (req0, 1+10) must hold
        set_op(3, 32'd7, 32'd3, 1'b1);
        req_valid = 4'b1000;
        rsp_ready = 1'b0;
        for (int c = 0; c < 3; c++) begin
            #1;
            chk($sformatf("t5_ready%0d", c), 64'(req_ready), 64'(0));
            chk_rsp($sformatf("t5_hold%0d", c), 2'd0, 32'd11, 1'b0, 1'b0);
            step();
        end
        rsp_ready = 1'b1;
        #1;
        chk("t5_grant3", 64'(req_ready), 64'(4'b1000));
        step();
        req_valid = '0;
        #1;
        chk_rsp("t5", 2'd3, 32'd4, 1'b1, 1'b0);
        step();
        chk("t5_idle", 64'(rsp_valid), 64'(0));

        // req2 sub 2-1, then a one-cycle pulse while stalled is ignored
        set_op(2, 32'd2, 32'd1, 1'b1);
        req_valid = 4'b0100;
        rsp_ready = 1'b0;
        #1;
        chk("t6_grant2", 64'(req_ready), 64'(4'b0100));
        step();
        req_valid = '0;
        set_op(0, 32'd5, 32'd5, 1'b0);
        #1;
        chk_rsp("t6a", 2'd2, 32'd1, 1'b1, 1'b0);
        req_valid = 4'b0001;
        #1;
        chk("t6_pulse_ready", 64'(req_ready), 64'(0));
        step();
        req_valid = '0;
        #1;
        chk_rsp("t6b", 2'd2, 32'd1, 1'b1, 1'b0);
        rsp_ready = 1'b1;
        step();
        chk("t6_idle", 64'(rsp_valid), 64'(0));

        // asynchronous reset while a result is held
        set_op(1, 32'd3, 32'd4, 1'b0);
        req_valid = 4'b0010;
        step();
        req_valid = 4'b0001;
        rsp_ready = 1'b0;
        #1;
        chk_rsp("t1_pre", 2'd1, 32'd7, 1'b0, 1'b0);
        reset = 1'b1;
        #1;
        chk("t1_valid", 64'(rsp_valid), 64'(0));
        chk("t1_sum",   64'(rsp_sum), 64'(0));
        chk("t1_id",    64'(rsp_id), 64'(0));
        chk("t1_ready", 64'(req_ready), 64'(0));
        req_valid = '0;
        step();
        reset = 1'b0;
        step();

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
